// File: rtl/io_writeback_if.sv
// Writeback channel bundle: device response channels in, one CPU writeback channel out.
// master = arbiter side, slave = device/CPU environment side.
interface io_writeback_if #(
  parameter int DATABITWIDTH = 16,
  parameter int DESTREGBITS  = 4,
  parameter int NUMPORTS     = 2
);
  logic [NUMPORTS-1:0]              Dev_REQ;
  logic [NUMPORTS-1:0]              Dev_ACK;
  logic [NUMPORTS-1:0]              Dev_RegFlag;
  logic [NUMPORTS-1:0]              Dev_MemFlag;
  logic [NUMPORTS*DESTREGBITS-1:0]  Dev_DestReg;
  logic [NUMPORTS*DATABITWIDTH-1:0] Dev_Data;
  logic                             WritebackREQ;
  logic                             WritebackACK;
  logic                             WritebackMemFlag;
  logic [DESTREGBITS-1:0]           WritebackDestReg;
  logic [DATABITWIDTH-1:0]          WritebackData;
  logic                             WritebackTimeout;

  // Handshake: a transfer happens on a rising edge with clk_en=1 where REQ && ACK;
  // the requester keeps its fields stable while REQ && !ACK.
  modport master (
    input  Dev_REQ, Dev_RegFlag, Dev_MemFlag, Dev_DestReg, Dev_Data, WritebackACK,
    output Dev_ACK, WritebackREQ, WritebackMemFlag, WritebackDestReg, WritebackData,
           WritebackTimeout
  );

  modport slave (
    output Dev_REQ, Dev_RegFlag, Dev_MemFlag, Dev_DestReg, Dev_Data, WritebackACK,
    input  Dev_ACK, WritebackREQ, WritebackMemFlag, WritebackDestReg, WritebackData,
           WritebackTimeout
  );
endinterface

// File: rtl/io_writeback_arbiter.sv
// Round-robin arbiter sharing the CPU IO writeback channel among NUMPORTS device channels,
// with one registered output stage. Optional stall timeout: define IOWB_TIMEOUT_EN.
module io_writeback_arbiter #(
  parameter int DATABITWIDTH  = 16,
  parameter int DESTREGBITS   = 4,
  parameter int NUMPORTS      = 2,
  parameter int TIMEOUTCYCLES = 1024
) (
  input  logic            clk,
  input  logic            async_rst_n,
  input  logic            clk_en,
  io_writeback_if.master  wb,
  output logic            o_dbg_state
);
  localparam int PW = (NUMPORTS > 1) ? $clog2(NUMPORTS) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_ptr;
  logic                    r_memflag;
  logic [DESTREGBITS-1:0]  r_destreg;
  logic [DATABITWIDTH-1:0] r_data;

  logic                    w_can_load;
  logic                    w_accept;
  logic                    w_grant_vld;
  logic [PW-1:0]           w_grant_idx;
  logic [NUMPORTS-1:0]     w_dev_ack;
  logic                    w_sel_reg;
  logic                    w_sel_mem;
  logic [DESTREGBITS-1:0]  w_sel_destreg;
  logic [DATABITWIDTH-1:0] w_sel_data;
  logic                    w_grant;
  logic                    w_load;
  logic                    w_timeout_hit;

  // Dev_ACK is held low during reset as well, so no device sees a phantom acceptance.
  assign w_can_load = async_rst_n && clk_en && ((r_state == EMPTY) || wb.WritebackACK);
  assign w_accept   = clk_en && (r_state == FULL) && wb.WritebackACK;

  // First requesting port at or after the pointer, wrapping around.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_idx       = '0;
    for (int k = 0; k < NUMPORTS; k++) begin
      v_idx = PW'((int'(r_ptr) + k) % NUMPORTS);
      if (!w_grant_vld && wb.Dev_REQ[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_sel_reg     = 1'b0;
    w_sel_mem     = 1'b0;
    w_sel_destreg = '0;
    w_sel_data    = '0;
    for (int i = 0; i < NUMPORTS; i++) begin
      if (w_grant_idx == PW'(i)) begin
        w_sel_reg     = wb.Dev_RegFlag[i];
        w_sel_mem     = wb.Dev_MemFlag[i];
        w_sel_destreg = wb.Dev_DestReg[i*DESTREGBITS +: DESTREGBITS];
        w_sel_data    = wb.Dev_Data[i*DATABITWIDTH +: DATABITWIDTH];
      end
    end
  end

  assign w_grant = w_can_load && w_grant_vld;
  // A response with neither flag is acknowledged but never enters the register.
  assign w_load  = w_grant && (w_sel_reg || w_sel_mem);

  always_comb begin
    w_dev_ack = '0;
    if (w_grant) w_dev_ack[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_load) w_state_nxt = FULL;
      FULL: begin
        if (w_load)             w_state_nxt = FULL;
        else if (w_accept)      w_state_nxt = EMPTY;
        else if (w_timeout_hit) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)  r_state <= EMPTY;
    else if (clk_en)   r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_ptr     <= '0;
      r_memflag <= 1'b0;
      r_destreg <= '0;
      r_data    <= '0;
    end else begin
      if (w_grant)
        r_ptr <= (w_grant_idx == PW'(NUMPORTS - 1)) ? '0 : w_grant_idx + 1'b1;
      if (w_load) begin
        r_memflag <= !w_sel_reg;
        r_destreg <= w_sel_destreg;
        r_data    <= w_sel_data;
      end
    end
  end

`ifdef IOWB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUTCYCLES + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_to_flag;

  assign w_timeout_hit = (r_state == FULL) && !wb.WritebackACK &&
                         (r_to_cnt == CW'(TIMEOUTCYCLES - 1));

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else if (clk_en) begin
      if ((r_state == FULL) && !wb.WritebackACK) begin
        if (w_timeout_hit) begin
          r_to_cnt  <= '0;
          r_to_flag <= 1'b1;
        end else begin
          r_to_cnt  <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign wb.WritebackTimeout = r_to_flag;
`else
  assign w_timeout_hit       = 1'b0;
  assign wb.WritebackTimeout = 1'b0;
`endif

  assign wb.Dev_ACK          = w_dev_ack;
  assign wb.WritebackREQ     = (r_state == FULL);
  assign wb.WritebackMemFlag = r_memflag;
  assign wb.WritebackDestReg = r_destreg;
  assign wb.WritebackData    = r_data;
  assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Directed bench for io_writeback_arbiter: reset, grant order, back-pressure, flag handling,
// clock enable, stall/timeout behaviour and asynchronous reset while full.
module tb_io_writeback_arbiter;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int NP = 2;

  logic clk;
  logic async_rst_n;
  logic clk_en;
  logic dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  io_writeback_if #(.DATABITWIDTH(DW), .DESTREGBITS(RW), .NUMPORTS(NP)) bus ();

  io_writeback_arbiter #(
    .DATABITWIDTH(DW), .DESTREGBITS(RW), .NUMPORTS(NP), .TIMEOUTCYCLES(16)
  ) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .wb(bus.master),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic rf, input logic mf,
                          input logic [RW-1:0] dest, input logic [DW-1:0] data);
    bus.Dev_REQ[p]            = req;
    bus.Dev_RegFlag[p]        = rf;
    bus.Dev_MemFlag[p]        = mf;
    bus.Dev_DestReg[p*RW +: RW] = dest;
    bus.Dev_Data[p*DW +: DW]  = data;
  endtask

  task automatic idle_ports();
    bus.Dev_REQ     = '0;
    bus.Dev_RegFlag = '0;
    bus.Dev_MemFlag = '0;
    bus.Dev_DestReg = '0;
    bus.Dev_Data    = '0;
  endtask

  task automatic check_out(input string tag, input logic req, input logic mf,
                           input logic [RW-1:0] dest, input logic [DW-1:0] data);
    check({tag, "_req"},  bus.WritebackREQ, req);
    check({tag, "_mem"},  bus.WritebackMemFlag, mf);
    check({tag, "_dest"}, bus.WritebackDestReg, dest);
    check({tag, "_data"}, bus.WritebackData, data);
  endtask

  initial begin
    logic [DW-1:0] d;
    int g;
    async_rst_n      = 1'b0;
    clk_en           = 1'b1;
    bus.WritebackACK = 1'b0;
    idle_ports();

    // 1. reset and idle
    repeat (3) tick();
    check_out("rst", 1'b0, 1'b0, 4'h0, 16'h0);
    check("rst_ack", bus.Dev_ACK, 2'b00);
    check("rst_to", bus.WritebackTimeout, 1'b0);
    @(negedge clk);
    async_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_req", bus.WritebackREQ, 1'b0);
      check("idle_ack", bus.Dev_ACK, 2'b00);
    end
    check_out("idle", 1'b0, 1'b0, 4'h0, 16'h0);

    // 2. single register response from port 0
    bus.WritebackACK = 1'b1;
    set_port(0, 1'b1, 1'b1, 1'b0, 4'h3, 16'hBEEF);
    #1 check("t2_ack", bus.Dev_ACK, 2'b01);
    tick();
    idle_ports();
    #1 check("t2_ack_low", bus.Dev_ACK, 2'b00);
    check_out("t2", 1'b1, 1'b0, 4'h3, 16'hBEEF);
    tick();
    check("t2_drain", bus.WritebackREQ, 1'b0);

    // 3. both ports requesting continuously; pointer now at port 1
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1'b1, 1'b1, 1'b0, 4'h1, 16'hA000 + 16'(k));
      set_port(1, 1'b1, 1'b1, 1'b0, 4'h2, 16'hB000 + 16'(k));
      g = (k % 2 == 0) ? 1 : 0;
      exp_q.push_back(g == 1 ? 16'hB000 + 16'(k) : 16'hA000 + 16'(k));
      #1 check("t3_ack", bus.Dev_ACK, (g == 1) ? 2'b10 : 2'b01);
      tick();
      d = exp_q.pop_front();
      check("t3_req", bus.WritebackREQ, 1'b1);
      check("t3_data", bus.WritebackData, d);
    end
    idle_ports();
    tick();
    check("t3_drain", bus.WritebackREQ, 1'b0);

    // 4. back-pressure: port 1 loads, then waits behind a stalled CPU
    bus.WritebackACK = 1'b0;
    set_port(1, 1'b1, 1'b1, 1'b0, 4'h5, 16'h5555);
    #1 check("t4_first_ack", bus.Dev_ACK, 2'b10);
    tick();
    set_port(1, 1'b1, 1'b1, 1'b0, 4'h6, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_hold_ack", bus.Dev_ACK, 2'b00);
      check("t4_hold_data", bus.WritebackData, 16'h5555);
      tick();
    end
    check_out("t4_held", 1'b1, 1'b0, 4'h5, 16'h5555);
    bus.WritebackACK = 1'b1;
    #1 check("t4_swap_ack", bus.Dev_ACK, 2'b10);
    tick();
    idle_ports();
    check_out("t4_swap", 1'b1, 1'b0, 4'h6, 16'h1234);
    tick();
    check("t4_drain", bus.WritebackREQ, 1'b0);

    // memory-only flag, then both flags (register wins)
    set_port(0, 1'b1, 1'b0, 1'b1, 4'h7, 16'h00AA);
    #1 check("mem_ack", bus.Dev_ACK, 2'b01);
    tick();
    idle_ports();
    check_out("mem", 1'b1, 1'b1, 4'h7, 16'h00AA);
    set_port(1, 1'b1, 1'b1, 1'b1, 4'h8, 16'h00BB);
    #1 check("both_ack", bus.Dev_ACK, 2'b10);
    tick();
    idle_ports();
    check_out("both", 1'b1, 1'b0, 4'h8, 16'h00BB);
    tick();
    check("both_drain", bus.WritebackREQ, 1'b0);

    // 5. flagless response is acknowledged and dropped; pointer still moves on
    set_port(0, 1'b1, 1'b0, 1'b0, 4'h9, 16'hDEAD);
    #1 check("drop_ack", bus.Dev_ACK, 2'b01);
    tick();
    idle_ports();
    check("drop_req", bus.WritebackREQ, 1'b0);
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hA, 16'h0A0A);
    set_port(1, 1'b1, 1'b1, 1'b0, 4'hB, 16'h0B0B);
    #1 check("drop_next_ack", bus.Dev_ACK, 2'b10);
    tick();
    idle_ports();
    check_out("drop_next", 1'b1, 1'b0, 4'hB, 16'h0B0B);
    tick();
    check("drop_drain", bus.WritebackREQ, 1'b0);

    // clock enable low freezes everything
    clk_en = 1'b0;
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hC, 16'hC0DE);
    #1 check("cen_ack", bus.Dev_ACK, 2'b00);
    tick();
    check("cen_req", bus.WritebackREQ, 1'b0);
    clk_en = 1'b1;
    #1 check("cen_on_ack", bus.Dev_ACK, 2'b01);
    tick();
    idle_ports();
    check_out("cen_on", 1'b1, 1'b0, 4'hC, 16'hC0DE);

    // 6. CPU stalls with an entry held
    bus.WritebackACK = 1'b0;
`ifdef IOWB_TIMEOUT_EN
    repeat (15) tick();
    check("to_before_req", bus.WritebackREQ, 1'b1);
    check("to_before_flag", bus.WritebackTimeout, 1'b0);
    tick();
    check("to_req", bus.WritebackREQ, 1'b0);
    check("to_flag", bus.WritebackTimeout, 1'b1);
    repeat (3) tick();
    check("to_sticky", bus.WritebackTimeout, 1'b1);
`else
    repeat (20) tick();
    check("stall_req", bus.WritebackREQ, 1'b1);
    check("stall_data", bus.WritebackData, 16'hC0DE);
    check("stall_to", bus.WritebackTimeout, 1'b0);
`endif

    // asynchronous reset while full; pointer was at port 1
    bus.WritebackACK = 1'b1;
    set_port(1, 1'b1, 1'b1, 1'b1, 4'hD, 16'h7777);
    #1 check("pre_rst_ack", bus.Dev_ACK, 2'b10);
    tick();
    check_out("pre_rst", 1'b1, 1'b0, 4'hD, 16'h7777);
    #2 async_rst_n = 1'b0;
    #1 check_out("async_rst", 1'b0, 1'b0, 4'h0, 16'h0);
    check("async_rst_ack", bus.Dev_ACK, 2'b00);
    check("async_rst_to", bus.WritebackTimeout, 1'b0);
    @(negedge clk);
    async_rst_n = 1'b1;
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hE, 16'hE0E0);
    #1 check("post_rst_ack", bus.Dev_ACK, 2'b01);
    tick();
    idle_ports();
    check_out("post_rst", 1'b1, 1'b0, 4'hE, 16'hE0E0);
    tick();
    check("post_rst_drain", bus.WritebackREQ, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time limit
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
